// File: rtl/uart_tx_shift_register.sv
// Parallel-in/serial-out UART transmit stage: validates a framed word, then
// paces it out LSB-first on tx at one bit per CLK_PER_BIT clocks.
module uart_tx_shift_register #(
  parameter int FRAME_W     = 10,
  parameter int CLK_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] in_sr,
  input  logic               load,
  output logic               ready,
  output logic               tx,
  output logic               busy,
  output logic               done,
  output logic               frame_err
);

  localparam int BAUD_W = $clog2(CLK_PER_BIT);
  localparam int BIT_W  = $clog2(FRAME_W);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                frame_err_q, frame_err_d;

  logic frame_ok;
  assign frame_ok = (in_sr[0] == 1'b0) && (in_sr[FRAME_W-1] == 1'b1);

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    shift_d     = shift_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          if (frame_ok) begin
            shift_d    = in_sr;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = SHIFT;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // Refill with mark so an over-shifted register still idles high.
            shift_d   = {1'b1, shift_q[FRAME_W-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next state so the flops present them aligned with it.
    tx_d    = (state_d == SHIFT) ? shift_d[0] : 1'b1;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == SHIFT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '1;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign tx        = tx_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_tx_shift_register.sv
// Directed bench for uart_tx_shift_register: table of frames with hand-written
// bit sequences, plus back-to-back, mid-frame load and mid-frame reset cases.
module tb_uart_tx_shift_register;

  localparam int FRAME_W = 10;
  localparam int CPB     = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [FRAME_W-1:0] in_sr;
  logic               load;
  logic               ready, tx, busy, done, frame_err;

  int total = 0;
  int bad   = 0;

  uart_tx_shift_register #(.FRAME_W(FRAME_W), .CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_sr     (in_sr),
    .load      (load),
    .ready     (ready),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FRAME_W-1:0] frame;
    logic               exp_err;
    logic [0:FRAME_W-1] exp_seq;  // tx level per bit slot, in transmit order
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in the first start-bit cycle, ends in the done cycle.
  task automatic stream_frame(input string tag, input logic [0:FRAME_W-1] exp_seq,
                              input int poke_bit, input logic keep_load);
    logic ok;
    logic bad_tx;
    for (int i = 0; i < FRAME_W; i++) begin
      ok = 1'b1;
      bad_tx = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (tx !== exp_seq[i] || busy !== 1'b1 || ready !== 1'b0 ||
            done !== 1'b0 || frame_err !== 1'b0) begin
          if (ok) bad_tx = tx;
          ok = 1'b0;
        end
        if (i == poke_bit && c == 3) begin
          in_sr = 10'b1_0_0000000_0;
          load  = 1'b1;
        end else if (!keep_load) begin
          load = 1'b0;
        end
        tick();
      end
      check($sformatf("%s bit%0d ok(tx=%0b)", tag, i, bad_tx), {31'd0, ok}, 32'd1);
    end
    check({tag, " done"},  {31'd0, done},  32'd1);
    check({tag, " tx_end"}, {31'd0, tx},   32'd1);
    check({tag, " ready_end"}, {31'd0, ready}, 32'd1);
    check({tag, " busy_end"},  {31'd0, busy},  32'd0);
  endtask

  task automatic start_load(input logic [FRAME_W-1:0] f);
    in_sr = f;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{frame: 10'b1_1_0000001_0, exp_err: 1'b0, exp_seq: 10'b0100000011};
    vecs[1] = '{frame: 10'b1_0_1011101_0, exp_err: 1'b0, exp_seq: 10'b0101110101};
    vecs[2] = '{frame: 10'b1_0_0000000_0, exp_err: 1'b0, exp_seq: 10'b0000000001};
    vecs[3] = '{frame: 10'b1_0_1010101_1, exp_err: 1'b1, exp_seq: 10'b1111111111};
    vecs[4] = '{frame: 10'b0_1_0000000_0, exp_err: 1'b1, exp_seq: 10'b1111111111};

    rst = 1'b1; load = 1'b0; in_sr = '0;
    #2;
    check("rst tx",        {31'd0, tx},        32'd1);
    check("rst ready",     {31'd0, ready},     32'd1);
    check("rst busy",      {31'd0, busy},      32'd0);
    check("rst done",      {31'd0, done},      32'd0);
    check("rst frame_err", {31'd0, frame_err}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Idle steadiness over 50 clocks.
    begin
      logic idle_ok = 1'b1;
      for (int c = 0; c < 50; c++) begin
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
        tick();
      end
      check("idle 50 clk", {31'd0, idle_ok}, 32'd1);
    end

    // Table: each frame either streams fully or is rejected with a frame_err pulse.
    for (int v = 0; v < 5; v++) begin
      start_load(vecs[v].frame);
      if (vecs[v].exp_err) begin
        check($sformatf("v%0d frame_err", v), {31'd0, frame_err}, 32'd1);
        check($sformatf("v%0d tx", v),        {31'd0, tx},        32'd1);
        check($sformatf("v%0d busy", v),      {31'd0, busy},      32'd0);
        tick();
        check($sformatf("v%0d frame_err off", v), {31'd0, frame_err}, 32'd0);
        check($sformatf("v%0d busy off", v),      {31'd0, busy},      32'd0);
      end else begin
        stream_frame($sformatf("v%0d", v), vecs[v].exp_seq, -1, 1'b0);
        tick();
        check($sformatf("v%0d done off", v), {31'd0, done}, 32'd0);
      end
      tick();
    end

    // Back-to-back with load held high: the restart happens in the done cycle.
    in_sr = 10'b1_0_1011101_0;
    load  = 1'b1;
    tick();
    stream_frame("b2b f1", 10'b0101110101, -1, 1'b1);
    tick();
    load = 1'b0;
    check("b2b restart busy", {31'd0, busy}, 32'd1);
    check("b2b restart tx",   {31'd0, tx},   32'd0);
    stream_frame("b2b f2", 10'b0101110101, -1, 1'b0);
    tick();
    check("b2b idle after", {31'd0, busy}, 32'd0);

    // Changing in_sr and pulsing load mid-frame must not disturb or queue anything.
    tick();
    start_load(10'b1_1_0000001_0);
    stream_frame("poke", 10'b0100000011, 4, 1'b0);
    load = 1'b0;
    begin
      logic quiet = 1'b1;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (busy !== 1'b0 || tx !== 1'b1 || frame_err !== 1'b0) quiet = 1'b0;
      end
      check("poke no queued frame", {31'd0, quiet}, 32'd1);
    end

    // Asynchronous reset during bit 5 takes effect between clock edges.
    start_load(10'b1_0_1011101_0);
    repeat (5 * CPB + 3) tick();
    check("pre-rst busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst tx",    {31'd0, tx},    32'd1);
    check("async rst busy",  {31'd0, busy},  32'd0);
    check("async rst ready", {31'd0, ready}, 32'd1);
    tick(); tick();
    rst = 1'b0;
    tick();
    start_load(10'b1_0_1011101_0);
    stream_frame("post-rst", 10'b0101110101, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
